// File: rtl/data_sync_pkg.sv
// Shared CDC definitions for the data_sync receive-path stage.
// Holds the legal synchronizer depth range, the capture-register reset value
// and a small range-check helper that is evaluated at elaboration.
package cdc_pkg;

    localparam int DATA_SYNC_MIN_STAGES = 2;
    localparam int DATA_SYNC_MAX_STAGES = 4;

    // Widest bus the reset constant covers; each instance slices what it needs.
    localparam int DATA_SYNC_MAX_WIDTH = 64;

    // Value loaded into sync_bus while Reset is high.
    localparam logic [DATA_SYNC_MAX_WIDTH-1:0] DATA_SYNC_BUS_RST = '0;

    function automatic bit data_sync_stages_legal(input int stages);
        return (stages >= DATA_SYNC_MIN_STAGES) && (stages <= DATA_SYNC_MAX_STAGES);
    endfunction

    function automatic bit data_sync_width_legal(input int width);
        return (width >= 1) && (width <= DATA_SYNC_MAX_WIDTH);
    endfunction

endpackage

// File: rtl/data_sync_if.sv
// Bus bundle between the asynchronous source side and data_sync.
// master: the source (drives data and qualifier, observes the result)
// slave : data_sync (samples data and qualifier, drives captured data and strobe)
interface data_sync_if #(
    parameter int Bus_Width = 8
);

    logic [Bus_Width-1:0] Unsync_bus;
    logic                 bus_enable;
    logic [Bus_Width-1:0] sync_bus;
    logic                 enable_pulse;

    modport master (
        output Unsync_bus,
        output bus_enable,
        input  sync_bus,
        input  enable_pulse
    );

    modport slave (
        input  Unsync_bus,
        input  bus_enable,
        output sync_bus,
        output enable_pulse
    );

endinterface

// File: rtl/data_sync_en_sync_chain.sv
// en_sync_chain: NUM_Stages-deep flop chain that brings the asynchronous
// enable into the CLK domain. Synchronous, active-high reset clears every stage
// so that an enable still high after reset is seen as a fresh 0->1.
module en_sync_chain #(
    parameter int NUM_Stages = 2
) (
    input  logic CLK,
    input  logic Reset,
    input  logic async_in,
    output logic sync_out
);

    logic [NUM_Stages-1:0] en_sync;

    // Shift the raw enable through the chain; stage 0 is the metastable capture flop.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            en_sync <= '0;
        end else begin
            en_sync <= {en_sync[NUM_Stages-2:0], async_in};
        end
    end

    assign sync_out = en_sync[NUM_Stages-1];

endmodule

// File: rtl/data_sync.sv
// data_sync: multi-bit CDC capture stage.
// The enable is synchronized through en_sync_chain, an edge detector finds the
// qualifying event, and on that single edge the quasi-static Unsync_bus is
// captured into sync_bus together with a one-cycle enable_pulse.
// Build option: define DATA_SYNC_TOGGLE_EN to treat bus_enable as a toggle
// (both transitions are events); otherwise only 0->1 of the level is an event.
module data_sync
    import cdc_pkg::*;
#(
    parameter int NUM_Stages = 2,
    parameter int Bus_Width  = 8
) (
    input  logic       CLK,
    input  logic       Reset,
    data_sync_if.slave bus
);

    generate
        if (!data_sync_stages_legal(NUM_Stages)) begin : g_bad_stages
            $error("data_sync: NUM_Stages=%0d outside %0d..%0d",
                   NUM_Stages, DATA_SYNC_MIN_STAGES, DATA_SYNC_MAX_STAGES);
        end
        if (!data_sync_width_legal(Bus_Width)) begin : g_bad_width
            $error("data_sync: Bus_Width=%0d outside 1..%0d",
                   Bus_Width, DATA_SYNC_MAX_WIDTH);
        end
    endgenerate

    localparam logic [Bus_Width-1:0] BUS_RST = DATA_SYNC_BUS_RST[Bus_Width-1:0];

    logic                 en_sync_q;
    logic                 pulse_prev;
    logic                 event_hit;
    logic [Bus_Width-1:0] sync_bus_r;
    logic                 enable_pulse_r;

    en_sync_chain #(
        .NUM_Stages (NUM_Stages)
    ) u_en_sync_chain (
        .CLK      (CLK),
        .Reset    (Reset),
        .async_in (bus.bus_enable),
        .sync_out (en_sync_q)
    );

    // Event detection on the synchronized enable against its one-cycle-old copy.
    always_comb begin
        event_hit = 1'b0;
`ifdef DATA_SYNC_TOGGLE_EN
        event_hit = en_sync_q ^ pulse_prev;
`else
        event_hit = en_sync_q & ~pulse_prev;
`endif
    end

    // Capture the bus only on the event edge; reset wins over a coincident event.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            pulse_prev     <= 1'b0;
            enable_pulse_r <= 1'b0;
            sync_bus_r     <= BUS_RST;
        end else begin
            pulse_prev     <= en_sync_q;
            enable_pulse_r <= event_hit;
            if (event_hit) begin
                sync_bus_r <= bus.Unsync_bus;
            end
        end
    end

    assign bus.sync_bus     = sync_bus_r;
    assign bus.enable_pulse = enable_pulse_r;

endmodule
